sdram_arbit: RTL

- Central arbiter and command multiplexer, directly downstream of the auto-refresh, init, write and read sub-blocks.
- Consumes the refresh request/command stream from the auto-refresh block and the equivalent streams from the init, write and read blocks.
- Grants exactly one requester at a time and drives the physical SDRAM command pins (cke, cs_n, ras_n, cas_n, we_n), bank and address.
- Fixed priority: refresh > write > read.

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_arbit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, arbiter state type and width defaults
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BA_W   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - fixed-priority (refresh > write > read) arbiter and SDRAM command mux
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int BA_W   = SDRAM_BA_W
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              flag_init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  output logic              ref_en,
  input  logic              flag_ref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  input  logic              flag_wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_bank,
  input  logic              rd_req,
  output logic              rd_en,
  input  logic              flag_rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_bank,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr
);

  arb_state_e state_q, state_d;

  logic [3:0]        cmd_sel;
  logic [BA_W-1:0]   bank_sel;
  logic [ADDR_W-1:0] addr_sel;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every grant returns through ARBIT, which guarantees a NOP cycle between owners.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flag_init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (ref_req)     state_d = ST_AREF;
        else if (wr_req) state_d = ST_WRITE;
        else if (rd_req) state_d = ST_READ;
      end
      ST_AREF: begin
        if (flag_ref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (flag_wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (flag_rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ref_en   = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    cmd_sel  = init_cmd;
    bank_sel = '0;
    addr_sel = init_addr;
    unique case (state_q)
      ST_IDLE: begin
        cmd_sel  = init_cmd;
        addr_sel = init_addr;
      end
      ST_ARBIT: begin
        cmd_sel  = CMD_NOP;
        addr_sel = '0;
      end
      ST_AREF: begin
        ref_en   = 1'b1;
        cmd_sel  = aref_cmd;
        addr_sel = aref_addr;
      end
      ST_WRITE: begin
        wr_en    = 1'b1;
        cmd_sel  = wr_cmd;
        bank_sel = wr_bank;
        addr_sel = wr_addr;
      end
      ST_READ: begin
        rd_en    = 1'b1;
        cmd_sel  = rd_cmd;
        bank_sel = rd_bank;
        addr_sel = rd_addr;
      end
      default: begin
        cmd_sel  = init_cmd;
        addr_sel = init_addr;
      end
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_bank = bank_sel;
  assign sdram_addr = addr_sel;

endmodule
